nested_loop_agu: RTL and testbench
==================================

# nested_loop_agu

Parametrised address generation unit for accelerator buffer and DMA access patterns. It walks up to NUM_LOOPS nested loops, each with a programmable trip count and signed stride, and emits one address per valid/ready handshake. Software loads the loop configuration over a register-write port, then issues a start. The block sits between the controller, which owns configuration and start/done, and a memory read/write port, which consumes addresses.

## Interface
- ADDR_WIDTH, 32, address and stride width
- NUM_LOOPS, 4, number of nested loops; loop 0 is innermost
- ITER_WIDTH, 16, trip-count field width
- LOOP_SEL_WIDTH, $clog2(NUM_LOOPS), loop-select width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_base_we  in  1  write base address
- cfg_base  in  ADDR_WIDTH  base address
- cfg_loop_we  in  1  write the selected loop's config
- cfg_loop_sel  in  LOOP_SEL_WIDTH  loop index
- cfg_loop_iter  in  ITER_WIDTH  trip count minus 1
- cfg_loop_stride  in  ADDR_WIDTH  signed two's-complement stride
- start  in  1  begin a walk
- busy  out  1  walk in progress
- done  out  1  one-cycle pulse after the final address is accepted
- addr_valid  out  1  addr_out is valid
- addr_ready  in  1  consumer accepts addr_out
- addr_out  out  ADDR_WIDTH  current address
- addr_last  out  1  addr_out is the final address of the walk

## Operation
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- States:
  - IDLE → RUN on start.
  - RUN → IDLE on a handshake (addr_valid && addr_ready) while addr_last = 1.
- Per-loop registers: iter_max[i] and stride[i] (config), plus cnt[i] and off[i] (run state).
- addr_out = base + Σ off[i], computed modulo 2^ADDR_WIDTH; wrap-around is silent.
- Handshake in RUN:
  - Loop 0 increments.
  - For each loop i that increments:
    - if cnt[i] == iter_max[i]: cnt[i] ← 0, off[i] ← 0, and loop i+1 increments (carry);
    - else: cnt[i] += 1, off[i] += stride[i].
- addr_last = RUN && cnt[i] == iter_max[i] for every i.
- Walk length is Π(iter_max[i]+1) addresses.
- An unconfigured loop (iter 0) executes one iteration and contributes offset 0.
- Config writes: accepted only in IDLE; ignored in RUN.
  - The base and a loop may be written in the same cycle.
  - start in the same cycle as a config write uses the old config.
- start in RUN is ignored.
- The walk proceeds on handshakes only; the block holds addr_out, addr_valid and addr_last stable while addr_ready = 0.

## Timing
- Reset values:
  - state IDLE; busy, done, addr_valid, addr_last = 0; addr_out = 0.
  - All cnt and off = 0; base = 0; iter_max = 0; stride = 0.
- start sampled high in IDLE at cycle T:
  - addr_valid = 1, busy = 1 and addr_out = base at T+1.
  - Counters and offsets are cleared at T+1.
- Throughput: one address per cycle while addr_ready = 1; the next address appears in the cycle after each handshake.
- Final handshake at cycle F: at F+1, done = 1 for exactly one cycle, state is IDLE, and busy = 0 and addr_valid = 0.
- start at F+1 is accepted; the next walk's first address appears at F+2.
- reset asserted mid-walk: at the next edge, all registers take reset values, done is not pulsed, and the configuration is lost.
- addr_out is 0 whenever addr_valid = 0.

## Structure
- Package agu_pkg holds:
  - the state encoding (IDLE, RUN);
  - the default widths ADDR_WIDTH, ITER_WIDTH and NUM_LOOPS.
- Sub-module agu_loop_counter, instantiated NUM_LOOPS times by generate:
  - holds iter_max, stride, cnt and off;
  - inputs: inc, clear;
  - outputs: wrap (carry) and off.
- The top level holds the FSM, the base register, the carry chain, the offset adder tree, and the addr_last/done logic.

## Test plan
- Single loop: base=0x1000, loop0 iter=3, stride=4, addr_ready held 1 → addresses 0x1000, 0x1004, 0x1008, 0x100C. addr_last is set on the 4th address. done pulses the cycle after.
- Two loops: loop0 iter=1 stride=1, loop1 iter=2 stride=0x10, base 0 → 0x0, 0x1, 0x10, 0x11, 0x20, 0x21, then done.
- Backpressure: addr_ready toggles 1,0,0,1,… → addr_out is held stable during stalls, no address is skipped or duplicated, and exactly Π(iter+1) handshakes occur.
- Negative stride and wrap: base=0x0000_0004, stride=0xFFFF_FFF8 (−8), iter=1 → 0x4, then 0xFFFF_FFFC.
- Config write and start during RUN are ignored (address stream unchanged). A reset asserted mid-walk returns all outputs to 0 next cycle with no done pulse.
- Back-to-back: start asserted in the done cycle → second walk's first address appears one cycle later. All-zero config → one address = base, then done.

Source files
------------

// File: rtl/agu_pkg.sv
// Shared types and default widths for the nested-loop address generation unit.
package agu_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_ITER_WIDTH = 16;
  localparam int DEF_NUM_LOOPS  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } agu_state_e;

endpackage

// File: rtl/agu_loop_counter.sv
// One loop level: holds its trip count and stride, and walks cnt/off on each increment.
module agu_loop_counter import agu_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ITER_WIDTH = DEF_ITER_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [ITER_WIDTH-1:0] cfg_iter,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic                  inc,
  input  logic                  clear,
  output logic                  at_max,
  output logic                  wrap,
  output logic [ADDR_WIDTH-1:0] off
);

  logic [ITER_WIDTH-1:0] iter_max;
  logic [ITER_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] stride;

  always_ff @(posedge clk) begin
    if (reset) begin
      iter_max <= '0;
      stride   <= '0;
    end else if (cfg_we) begin
      iter_max <= cfg_iter;
      stride   <= cfg_stride;
    end
  end

  // Offset accumulates the stride so no multiplier is needed; it wraps silently.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
      off <= '0;
    end else if (inc) begin
      if (at_max) begin
        cnt <= '0;
        off <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        off <= off + stride;
      end
    end
  end

  assign at_max = (cnt == iter_max);
  assign wrap   = inc && at_max;

endmodule

// File: rtl/nested_loop_agu.sv
// Nested-loop address generator: base + sum of per-loop offsets, one address per handshake.
module nested_loop_agu import agu_pkg::*; #(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int NUM_LOOPS      = DEF_NUM_LOOPS,
  parameter int ITER_WIDTH     = DEF_ITER_WIDTH,
  parameter int LOOP_SEL_WIDTH = $clog2(NUM_LOOPS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_base_we,
  input  logic [ADDR_WIDTH-1:0]     cfg_base,
  input  logic                      cfg_loop_we,
  input  logic [LOOP_SEL_WIDTH-1:0] cfg_loop_sel,
  input  logic [ITER_WIDTH-1:0]     cfg_loop_iter,
  input  logic [ADDR_WIDTH-1:0]     cfg_loop_stride,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      addr_valid,
  input  logic                      addr_ready,
  output logic [ADDR_WIDTH-1:0]     addr_out,
  output logic                      addr_last
);

  // Handshake: an address transfers in every cycle where addr_valid && addr_ready;
  // while addr_ready is low, addr_out, addr_valid and addr_last hold their values.

  agu_state_e            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] off [NUM_LOOPS];
  logic [ADDR_WIDTH-1:0] off_sum;
  logic [NUM_LOOPS-1:0]  carry;
  logic [NUM_LOOPS-1:0]  wrap;
  logic [NUM_LOOPS-1:0]  at_max;
  logic                  hs;
  logic                  cfg_ok;
  logic                  walk_clear;

  assign hs         = addr_valid && addr_ready;
  // A start in the same cycle as a config write launches with the old config.
  assign cfg_ok     = (state == IDLE) && !start;
  assign walk_clear = (state == IDLE) && start;

  for (genvar i = 0; i < NUM_LOOPS; i++) begin : g_loop
    logic sel_hit;
    assign sel_hit = cfg_loop_we && cfg_ok && (cfg_loop_sel == LOOP_SEL_WIDTH'(i));

    if (i == 0) begin : g_first
      assign carry[i] = hs;
    end else begin : g_rest
      assign carry[i] = wrap[i-1];
    end

    agu_loop_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ITER_WIDTH (ITER_WIDTH)
    ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .cfg_we     (sel_hit),
      .cfg_iter   (cfg_loop_iter),
      .cfg_stride (cfg_loop_stride),
      .inc        (carry[i]),
      .clear      (walk_clear),
      .at_max     (at_max[i]),
      .wrap       (wrap[i]),
      .off        (off[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base <= '0;
    end else if (cfg_base_we && cfg_ok) begin
      base <= cfg_base;
    end
  end

  always_comb begin
    off_sum = base;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      off_sum = off_sum + off[i];
    end
  end

  // The outermost carry fires exactly on the handshake of the final address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      addr_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            addr_valid <= 1'b1;
          end
        end
        RUN: begin
          if (wrap[NUM_LOOPS-1]) begin
            state      <= IDLE;
            busy       <= 1'b0;
            addr_valid <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign addr_out  = addr_valid ? off_sum : '0;
  assign addr_last = (state == RUN) && (&at_max);

endmodule

// File: tb/tb_nested_loop_agu.sv
// Scoreboard bench for nested_loop_agu: expected addresses queued at start, checked on handshakes.
module tb_nested_loop_agu;

  localparam int AW = 32;
  localparam int IW = 16;
  localparam int NL = 4;
  localparam int SW = 2;
  localparam int W  = AW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_base_we;
  logic [AW-1:0] cfg_base;
  logic          cfg_loop_we;
  logic [SW-1:0] cfg_loop_sel;
  logic [IW-1:0] cfg_loop_iter;
  logic [AW-1:0] cfg_loop_stride;
  logic          start;
  logic          busy;
  logic          done;
  logic          addr_valid;
  logic          addr_ready;
  logic [AW-1:0] addr_out;
  logic          addr_last;

  logic [W-1:0]  exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_hs  = 0;
  bit            pend_done = 0;
  bit            walk_done = 0;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic          prev_last;

  logic [AW-1:0] m_base;
  logic [IW-1:0] m_iter [NL];
  logic [AW-1:0] m_stride [NL];

  nested_loop_agu dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_base_we     (cfg_base_we),
    .cfg_base        (cfg_base),
    .cfg_loop_we     (cfg_loop_we),
    .cfg_loop_sel    (cfg_loop_sel),
    .cfg_loop_iter   (cfg_loop_iter),
    .cfg_loop_stride (cfg_loop_stride),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .addr_valid      (addr_valid),
    .addr_ready      (addr_ready),
    .addr_out        (addr_out),
    .addr_last       (addr_last)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      prev_stall = 0;
      pend_done  = 0;
    end else begin
      if (pend_done) begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_valid", addr_valid, 0);
        pend_done = 0;
        walk_done = 1;
      end else if (done) begin
        check("spurious_done", done, 0);
      end
      if (prev_stall) begin
        check("hold_valid", addr_valid, 1);
        check("hold_addr", addr_out, prev_addr);
        check("hold_last", addr_last, prev_last);
      end
      if (!addr_valid) check("idle_addr", addr_out, 0);
      if (addr_valid && addr_ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          check("extra_addr", addr_out, 0);
          check("extra_addr_present", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("addr", addr_out, e[AW-1:0]);
          check("last", addr_last, e[AW]);
        end
        if (addr_last) pend_done = 1;
      end
      prev_stall = addr_valid && !addr_ready;
      prev_addr  = addr_out;
      prev_last  = addr_last;
    end
  end

  function automatic bit ready_pat(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // reference model: decompose the walk index in mixed radix
  task automatic push_walk(output int len);
    len = 1;
    for (int i = 0; i < NL; i++) len = len * (int'(m_iter[i]) + 1);
    for (int k = 0; k < len; k++) begin
      int idx;
      int r;
      logic [AW-1:0] a;
      idx = k;
      a = m_base;
      for (int i = 0; i < NL; i++) begin
        r = int'(m_iter[i]) + 1;
        a = a + AW'(idx % r) * m_stride[i];
        idx = idx / r;
      end
      exp_q.push_back({(k == len - 1), a});
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input bit last);
    exp_q.push_back({last, a});
  endtask

  task automatic clear_model();
    m_base = '0;
    for (int i = 0; i < NL; i++) begin
      m_iter[i] = '0;
      m_stride[i] = '0;
    end
  endtask

  // driver tasks
  task automatic write_base(input logic [AW-1:0] b);
    @(posedge clk); #1;
    cfg_base_we = 1; cfg_base = b;
    @(posedge clk); #1;
    cfg_base_we = 0;
    m_base = b;
  endtask

  task automatic write_loop(input int sel, input logic [IW-1:0] it, input logic [AW-1:0] st);
    @(posedge clk); #1;
    cfg_loop_we = 1; cfg_loop_sel = SW'(sel); cfg_loop_iter = it; cfg_loop_stride = st;
    @(posedge clk); #1;
    cfg_loop_we = 0;
    m_iter[sel] = it; m_stride[sel] = st;
  endtask

  task automatic write_both(input logic [AW-1:0] b, input int sel, input logic [IW-1:0] it,
                            input logic [AW-1:0] st);
    @(posedge clk); #1;
    cfg_base_we = 1; cfg_base = b;
    cfg_loop_we = 1; cfg_loop_sel = SW'(sel); cfg_loop_iter = it; cfg_loop_stride = st;
    @(posedge clk); #1;
    cfg_base_we = 0; cfg_loop_we = 0;
    m_base = b; m_iter[sel] = it; m_stride[sel] = st;
  endtask

  task automatic run_walk(input int mode, input bit poke_run, input bit poke_start, input int len);
    int cyc;
    int hs0;
    hs0 = n_hs;
    walk_done = 0;
    @(posedge clk); #1;
    start = 1;
    if (poke_start) begin
      cfg_base_we = 1; cfg_base = 32'h0000_3000;
    end
    @(posedge clk); #1;
    start = 0; cfg_base_we = 0;
    addr_ready = ready_pat(mode, 0);
    @(negedge clk);
    check("start_valid", addr_valid, 1);
    check("start_busy", busy, 1);
    cyc = 1;
    while (!walk_done && cyc < 400) begin
      @(posedge clk); #1;
      start = 0; cfg_base_we = 0; cfg_loop_we = 0;
      if (poke_run && cyc == 2) begin
        start = 1;
        cfg_base_we = 1; cfg_base = 32'hDEAD_0000;
        cfg_loop_we = 1; cfg_loop_sel = 0; cfg_loop_iter = 16'd7; cfg_loop_stride = 32'h999;
      end
      addr_ready = ready_pat(mode, cyc);
      cyc++;
    end
    start = 0; cfg_base_we = 0; cfg_loop_we = 0; addr_ready = 0;
    check("walk_timeout", walk_done, 1);
    check("hs_count", n_hs - hs0, len);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic back_to_back();
    int len;
    int cyc;
    int hs0;
    bit fired;
    push_walk(len);
    push_walk(len);
    hs0 = n_hs; walk_done = 0; fired = 0; cyc = 0;
    @(posedge clk); #1;
    start = 1; addr_ready = 1;
    @(posedge clk); #1;
    start = 0;
    while (!fired && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (pend_done) begin
        start = 1;
        fired = 1;
      end
    end
    check("b2b_fired", fired, 1);
    @(posedge clk); #1;
    start = 0; walk_done = 0;
    @(negedge clk);
    check("b2b_valid", addr_valid, 1);
    cyc = 0;
    while (!walk_done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    addr_ready = 0;
    check("b2b_timeout", walk_done, 1);
    check("b2b_hs", n_hs - hs0, 2 * len);
    check("b2b_queue", exp_q.size(), 0);
  endtask

  task automatic reset_mid_walk();
    int len;
    push_walk(len);
    walk_done = 0;
    @(posedge clk); #1;
    start = 1; addr_ready = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_done", done, 0);
    check("rst_addr", addr_out, 0);
    check("rst_last", addr_last, 0);
    @(posedge clk); #1;
    reset = 0; addr_ready = 0;
    exp_q.delete();
    clear_model();
    repeat (2) @(negedge clk);
    check("rst_no_done", done, 0);
    check("rst_no_walk", walk_done, 0);
  endtask

  initial begin
    int len;
    reset = 1; start = 0; addr_ready = 0;
    cfg_base_we = 0; cfg_base = '0;
    cfg_loop_we = 0; cfg_loop_sel = '0; cfg_loop_iter = '0; cfg_loop_stride = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", addr_valid, 0);
    check("reset_addr", addr_out, 0);
    check("reset_last", addr_last, 0);

    // single loop
    write_base(32'h1000);
    write_loop(0, 16'd3, 32'd4);
    push_exp(32'h1000, 0); push_exp(32'h1004, 0); push_exp(32'h1008, 0); push_exp(32'h100C, 1);
    run_walk(0, 0, 0, 4);

    // two loops, base and loop 0 written together
    write_both(32'h0, 0, 16'd1, 32'd1);
    write_loop(1, 16'd2, 32'h10);
    push_exp(32'h0, 0); push_exp(32'h1, 0); push_exp(32'h10, 0);
    push_exp(32'h11, 0); push_exp(32'h20, 0); push_exp(32'h21, 1);
    run_walk(0, 0, 0, 6);

    // backpressure: fixed pattern, then random
    write_loop(2, 16'd1, 32'h100);
    push_walk(len);
    run_walk(1, 0, 0, len);
    write_loop(3, 16'd2, 32'hFFFF_FFFC);
    push_walk(len);
    run_walk(2, 0, 0, len);

    // negative stride with wrap-around
    for (int i = 1; i < NL; i++) write_loop(i, 16'd0, 32'd0);
    write_both(32'h4, 0, 16'd1, 32'hFFFF_FFF8);
    push_exp(32'h4, 0); push_exp(32'hFFFF_FFFC, 1);
    run_walk(0, 0, 0, 2);

    // config write and start while running are ignored
    write_base(32'h2000);
    write_loop(0, 16'd3, 32'h20);
    push_walk(len);
    run_walk(1, 1, 0, len);
    push_walk(len);
    run_walk(0, 0, 0, len);

    // start with a same-cycle base write launches with the old base
    push_walk(len);
    run_walk(0, 0, 1, len);
    write_base(32'h3000);
    push_walk(len);
    run_walk(2, 0, 0, len);

    back_to_back();

    // reset mid-walk loses configuration; all-zero config gives one address
    reset_mid_walk();
    push_walk(len);
    run_walk(0, 0, 0, len);
    write_base(32'h55);
    push_walk(len);
    run_walk(1, 0, 0, len);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
